// File: rtl/result_drain.sv
// result_drain: walks the core result memory after finish, buffers words in a FIFO, streams them out.
// Optional feature macro: RESULT_CHECKSUM_EN (running mod-2**DATA_W sum of drained words on checksum).
// Ports: clk, rst (sync, active-low); finish edge starts a drain; read_n/r_addr/ry/read_data core read port;
//   out_valid/out_ready/out_data/out_last output stream; busy, drain_done pulse, err_timeout (sticky), checksum.
module result_drain #(
  parameter int NUM_RESULTS  = 16,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 9,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              finish,
  input  logic              ry,
  input  logic [DATA_W-1:0] read_data,
  output logic              read_n,
  output logic [ADDR_W-1:0] r_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              drain_done,
  output logic              err_timeout,
  output logic [DATA_W-1:0] checksum
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(READ_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, GAP, FLUSH, DONE} state_t;
  state_t state_q;
  logic finish_q;
  logic [ADDR_W-1:0] addr_q;
  logic [TW-1:0] timer_q;
  logic [DATA_W:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0] cnt_q;
  logic start, push, pop, at_end;
  assign start = state_q == IDLE && finish && !finish_q;
  assign at_end = addr_q == ADDR_W'(NUM_RESULTS - 1);
  assign push = state_q == WAIT && ry;
  assign pop = out_valid && out_ready;
  assign out_valid = cnt_q != '0;
  // Entries carry {last, data}; the head reads as zero whenever the FIFO is empty.
  assign out_data = out_valid ? mem_q[rd_q][DATA_W-1:0] : '0;
  assign out_last = out_valid && mem_q[rd_q][DATA_W];
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      finish_q    <= 1'b0;
      addr_q      <= '0;
      timer_q     <= '0;
      read_n      <= 1'b1;
      r_addr      <= '0;
      busy        <= 1'b0;
      drain_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      finish_q   <= finish;
      drain_done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          addr_q      <= '0;
          err_timeout <= 1'b0;
          busy        <= 1'b1;
          state_q     <= REQ;
        end
        // Issue a read only when its word is guaranteed a FIFO slot.
        REQ: if (cnt_q < (PW+1)'(FIFO_DEPTH)) begin
          read_n  <= 1'b0;
          r_addr  <= addr_q;
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: if (ry) begin
          read_n  <= 1'b1;
          state_q <= GAP;
        end else if (timer_q == TW'(READ_TIMEOUT - 1)) begin
          read_n      <= 1'b1;
          err_timeout <= 1'b1;
          state_q     <= FLUSH;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
        GAP: if (at_end) state_q <= FLUSH;
          else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= REQ;
          end
        FLUSH: if (!out_valid) begin
          drain_done <= 1'b1;
          busy       <= 1'b0;
          state_q    <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= {at_end, read_data};
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
`ifdef RESULT_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  always_ff @(posedge clk) begin
    if (!rst) sum_q <= '0;
    else if (start) sum_q <= '0;
    else if (push) sum_q <= sum_q + read_data;
  end
  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: table-driven and randomized drains of result_drain checked against a word-list model.
module tb_result_drain;
  localparam int N = 4, AW = 8, DW = 9, DEPTH = 4, TO = 15;
  logic clk = 1'b0, rst = 1'b0, finish = 1'b0, ry = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] read_data = '0;
  logic read_n, out_valid, out_last, busy, drain_done, err_timeout;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] out_data, checksum;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  result_drain #(.NUM_RESULTS(N), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .READ_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .finish(finish), .ry(ry), .read_data(read_data), .read_n(read_n),
    .r_addr(r_addr), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .drain_done(drain_done), .err_timeout(err_timeout),
    .checksum(checksum)
  );
  typedef struct {
    logic [N-1:0][DW-1:0] d;
    int lat, wh, rmode, nw, err, ck;
  } vec_t;
  logic [DW-1:0] mem [N];
  int lat = 0, wh = 99, rmode = 0, low_cnt = 0, reads = 0, done_cnt = 0;
  int run_len [N];
  int rd_addrs [$];
  logic [DW:0] got [$];
  bit noise = 1'b1, released = 1'b0, hold_prev = 1'b0;
  logic [DW:0] prev_head = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Core memory responder and stream consumer; decisions made here are seen by the next rising edge.
  always @(negedge clk) begin
    if (drain_done) done_cnt++;
    if (hold_prev && rst) chk("head_stable", {out_last, out_data}, prev_head);
    if (!read_n) begin
      if (low_cnt == 0) begin
        reads++;
        rd_addrs.push_back(int'(r_addr));
        chk("fifo_space", reads <= got.size() + DEPTH, 1);
      end
      low_cnt++;
      ry = (int'(r_addr) != wh) && (low_cnt > lat);
      read_data = mem[r_addr[1:0]];
    end else begin
      if (low_cnt != 0 && rd_addrs.size() != 0) run_len[rd_addrs[rd_addrs.size()-1] % N] = low_cnt;
      low_cnt = 0;
      ry = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      read_data = DW'($urandom);
    end
    out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? released : 1'($urandom_range(0, 1));
    if (out_valid && out_ready) got.push_back({out_last, out_data});
    hold_prev = out_valid && !out_ready;
    prev_head = {out_last, out_data};
  end
  function automatic vec_t model(input logic [N-1:0][DW-1:0] d, input int l, input int w, input int rm);
    vec_t v;
    int s = 0;
    v.d = d; v.lat = l; v.wh = w; v.rmode = rm;
    v.nw = w < N ? w : N;
    v.err = w < N ? 1 : 0;
    for (int i = 0; i < v.nw; i++) s += int'(d[i]);
    v.ck = s % (1 << DW);
    return v;
  endfunction
  task automatic load(input vec_t v);
    for (int i = 0; i < N; i++) mem[i] = v.d[i];
    lat = v.lat; wh = v.wh; rmode = v.rmode; released = 1'b0;
    got.delete(); rd_addrs.delete(); reads = 0; done_cnt = 0;
  endtask
  task automatic wait_done(input string tag);
    for (int t = 0; t < 3000 && done_cnt == 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, " done_once"}, done_cnt, 1);
  endtask
  task automatic run_drain(input vec_t v, input string tag);
    int exp_reads = v.wh < N ? v.wh + 1 : N;
    load(v);
    @(negedge clk) finish = 1'b1;
    @(negedge clk) finish = 1'b0;
    chk({tag, " busy"}, busy, 1);
    chk({tag, " err_clr"}, err_timeout, 0);
    repeat (5) @(negedge clk);
    finish = 1'b1;
    @(negedge clk) finish = 1'b0;
    if (v.rmode == 1) begin
      repeat (40) @(negedge clk);
      chk({tag, " stall_reads"}, reads, DEPTH);
      chk({tag, " stall_read_n"}, read_n, 1);
      released = 1'b1;
    end
    wait_done(tag);
    chk({tag, " nwords"}, got.size(), v.nw);
    for (int i = 0; i < got.size() && i < v.nw; i++)
      chk($sformatf("%s word%0d", tag, i), got[i], {i == N - 1, v.d[i]});
    chk({tag, " err"}, err_timeout, v.err);
`ifdef RESULT_CHECKSUM_EN
    chk({tag, " cksum"}, checksum, v.ck);
`else
    chk({tag, " cksum"}, checksum, 0);
`endif
    chk({tag, " reads"}, reads, exp_reads);
    for (int i = 0; i < rd_addrs.size(); i++) chk($sformatf("%s addr%0d", tag, i), rd_addrs[i], i);
    if (v.wh < N) chk({tag, " timeout_len"}, run_len[v.wh], TO);
    chk({tag, " idle"}, {busy, read_n, out_valid}, 3'b010);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " read_n"}, read_n, 1);
    chk({tag, " r_addr"}, r_addr, 0);
    chk({tag, " stream"}, {out_valid, out_data, out_last}, 0);
    chk({tag, " status"}, {busy, drain_done, err_timeout}, 0);
    chk({tag, " cksum"}, checksum, 0);
  endtask
  vec_t tv [5];
  initial begin
    tv[0] = '{d: {9'h050, 9'h1FF, 9'h002, 9'h101}, lat: 1, wh: 99, rmode: 0, nw: 4, err: 0, ck: 'h152};
    tv[1] = '{d: {9'h033, 9'h044, 9'h002, 9'h1FF}, lat: 1, wh: 2, rmode: 2, nw: 2, err: 1, ck: 'h001};
    tv[2] = '{d: {9'h00F, 9'h0F0, 9'h155, 9'h0AA}, lat: 0, wh: 99, rmode: 1, nw: 4, err: 0, ck: 'h0FE};
    tv[3] = '{d: {9'h111, 9'h122, 9'h133, 9'h144}, lat: 2, wh: 0, rmode: 2, nw: 0, err: 1, ck: 'h000};
    tv[4] = '{d: {9'h040, 9'h030, 9'h020, 9'h010}, lat: 0, wh: 3, rmode: 2, nw: 3, err: 1, ck: 'h060};
    for (int i = 0; i < N; i++) begin mem[i] = '0; run_len[i] = 0; end
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) run_drain(tv[i], $sformatf("vec%0d", i));
    // Finish held high across the end of a drain must not start another one.
    load(tv[0]);
    @(negedge clk) finish = 1'b1;
    wait_done("held");
    reads = 0;
    repeat (30) @(negedge clk);
    chk("held no_redrain", {reads[7:0], busy}, 0);
    finish = 1'b0;
    // Reset while waiting on ry discards the buffered word and the read in flight.
    load(tv[1]);
    wh = 1; rmode = 1;
    @(negedge clk) finish = 1'b1;
    @(negedge clk) finish = 1'b0;
    for (int t = 0; t < 200 && !(read_n == 1'b0 && r_addr == 8'd1); t++) @(negedge clk);
    chk("midreset in_wait", {read_n, r_addr}, 9'h001);
    chk("midreset buffered", out_valid, 1);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("midreset");
    @(negedge clk) rst = 1'b1;
    done_cnt = 0;
    repeat (30) @(negedge clk);
    chk("midreset no_done", {done_cnt[7:0], busy}, 0);
    for (int k = 0; k < 8; k++) begin
      logic [N-1:0][DW-1:0] d;
      for (int i = 0; i < N; i++) d[i] = DW'($urandom);
      run_drain(model(d, $urandom_range(0, 3), ($urandom_range(0, 2) == 0) ? $urandom_range(0, N - 1) : 99,
                      $urandom_range(0, 1) * 2), $sformatf("rnd%0d", k));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
